// File: rtl/beta_exe_lsu.sv
// ============================================================================
// Module   : beta_exe_lsu
// Brief    : Execute-stage load/store unit. Issues one memory operation at a
//            time on a req/gnt/rvalid port; aligns store data and extends loads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beta_exe_lsu #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 lsu_en_i,
    input  logic                 lsu_op_i,
    input  logic [1:0]           lsu_op_size_i,
    input  logic                 lsu_unsigned_i,
    input  logic [AddrWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_busy_o,
    output logic                 lsu_valid_o,
    output logic                 lsu_misaligned_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [AddrWidth-1:0] data_addr_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic                 data_rvalid_i,
    input  logic [DataWidth-1:0] data_rdata_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_err  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_op;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic                 r_valid;
    logic                 r_misaligned;
    logic [DataWidth-1:0] r_rdata;

    logic                 w_misaligned;
    logic                 w_req;
    logic [1:0]           w_off;
    logic [3:0]           w_be;
    logic [DataWidth-1:0] w_wdata;
    logic [DataWidth-1:0] w_shifted;
    logic [DataWidth-1:0] w_load;

    always_comb begin
        w_misaligned = 1'b0;
        case (lsu_op_size_i)
            2'b01:   w_misaligned = lsu_addr_i[0];
            2'b10:   w_misaligned = (lsu_addr_i[1:0] != 2'b00);
            2'b11:   w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_req     = (r_state == c_st_req);
    assign w_off     = r_addr[1:0];
    assign w_shifted = data_rdata_i >> {w_off, 3'b000};

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        w_load  = w_shifted;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{r_wdata[7:0]}};
                w_load  = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{r_wdata[15:0]}};
                w_load  = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
                w_load  = w_shifted;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= c_st_idle;
            r_op         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (lsu_en_i) begin
                        r_op       <= lsu_op_i;
                        r_size     <= lsu_op_size_i;
                        r_unsigned <= lsu_unsigned_i;
                        r_addr     <= lsu_addr_i;
                        r_wdata    <= lsu_wdata_i;
                        r_state    <= w_misaligned ? c_st_err : c_st_req;
                    end
                end
                c_st_req: begin
                    if (data_gnt_i) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (data_rvalid_i) begin
                        r_state <= c_st_idle;
                        r_valid <= 1'b1;
                        if (!r_op) begin
                            r_rdata <= w_load;
                        end
                    end
                end
                c_st_err: begin
                    r_state      <= c_st_idle;
                    r_misaligned <= 1'b1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Bus fields are forced to zero outside REQ so nothing stale is presented.
    assign data_req_o       = w_req;
    assign data_we_o        = w_req & r_op;
    assign data_be_o        = w_req ? w_be : 4'b0000;
    assign data_addr_o      = w_req ? {r_addr[AddrWidth-1:2], 2'b00} : '0;
    assign data_wdata_o     = w_req ? w_wdata : '0;
    assign lsu_busy_o       = (r_state != c_st_idle);
    assign lsu_valid_o      = r_valid;
    assign lsu_misaligned_o = r_misaligned;
    assign lsu_rdata_o      = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_beta_exe_lsu.sv
// ============================================================================
// Module   : tb_beta_exe_lsu
// Brief    : Directed self-checking bench for beta_exe_lsu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beta_exe_lsu;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        lsu_en_i;
    logic        lsu_op_i;
    logic [1:0]  lsu_op_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_valid_o;
    logic        lsu_misaligned_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int checks = 0;
    int errors = 0;

    beta_exe_lsu dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .lsu_en_i         (lsu_en_i),
        .lsu_op_i         (lsu_op_i),
        .lsu_op_size_i    (lsu_op_size_i),
        .lsu_unsigned_i   (lsu_unsigned_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_busy_o       (lsu_busy_o),
        .lsu_valid_o      (lsu_valid_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mem_op(input logic op, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gdly, input int rdly, input logic [31:0] rd,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd);
        chk("idle_busy", {31'd0, lsu_busy_o}, 32'd0);
        lsu_en_i       = 1'b1;
        lsu_op_i       = op;
        lsu_op_size_i  = size;
        lsu_unsigned_i = uns;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        tick();
        lsu_en_i = 1'b0;
        for (int i = 0; i <= gdly; i++) begin
            chk("req",   {31'd0, data_req_o}, 32'd1);
            chk("busy",  {31'd0, lsu_busy_o}, 32'd1);
            chk("we",    {31'd0, data_we_o},  {31'd0, op});
            chk("be",    {28'd0, data_be_o},  {28'd0, ebe});
            chk("addr",  data_addr_o, {addr[31:2], 2'b00});
            if (op) chk("wdata", data_wdata_o, ewd);
            data_gnt_i = (i == gdly);
            tick();
        end
        data_gnt_i = 1'b0;
        for (int j = 0; j <= rdly; j++) begin
            chk("wait_req",  {31'd0, data_req_o}, 32'd0);
            chk("wait_busy", {31'd0, lsu_busy_o}, 32'd1);
            data_rvalid_i = (j == rdly);
            data_rdata_i  = rd;
            tick();
        end
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk("done_busy",  {31'd0, lsu_busy_o},       32'd0);
        chk("done_valid", {31'd0, lsu_valid_o},      32'd1);
        chk("done_mis",   {31'd0, lsu_misaligned_o}, 32'd0);
        chk("rdata",      lsu_rdata_o, erd);
        tick();
        chk("valid_pulse", {31'd0, lsu_valid_o}, 32'd0);
    endtask

    task automatic mis_op(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] erd);
        lsu_en_i      = 1'b1;
        lsu_op_i      = 1'b0;
        lsu_op_size_i = size;
        lsu_addr_i    = addr;
        tick();
        lsu_en_i = 1'b0;
        chk("err_busy", {31'd0, lsu_busy_o},       32'd1);
        chk("err_req",  {31'd0, data_req_o},       32'd0);
        chk("err_mis0", {31'd0, lsu_misaligned_o}, 32'd0);
        tick();
        chk("mis_busy",  {31'd0, lsu_busy_o},       32'd0);
        chk("mis_pulse", {31'd0, lsu_misaligned_o}, 32'd1);
        chk("mis_valid", {31'd0, lsu_valid_o},      32'd0);
        chk("mis_req",   {31'd0, data_req_o},       32'd0);
        chk("mis_rdata", lsu_rdata_o, erd);
        tick();
        chk("mis_clear", {31'd0, lsu_misaligned_o}, 32'd0);
    endtask

    initial begin
        rstn_i         = 1'b0;
        lsu_en_i       = 1'b0;
        lsu_op_i       = 1'b0;
        lsu_op_size_i  = 2'b00;
        lsu_unsigned_i = 1'b0;
        lsu_addr_i     = 32'h0;
        lsu_wdata_i    = 32'h0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = 32'h0;
        tick();
        chk("rst_busy",  {31'd0, lsu_busy_o},  32'd0);
        chk("rst_req",   {31'd0, data_req_o},  32'd0);
        chk("rst_valid", {31'd0, lsu_valid_o}, 32'd0);
        chk("rst_be",    {28'd0, data_be_o},   32'd0);
        chk("rst_rdata", lsu_rdata_o,          32'd0);
        tick();
        rstn_i = 1'b1;
        tick();

        // Loads and stores: op, size, uns, addr, wdata, gnt delay, rvalid delay, rdata, be, wdata, result
        mem_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        mem_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0, 0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 0, 0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080);
        mem_op(1'b0, 2'b01, 1'b0, 32'h206, 32'h0, 1, 1, 32'hBEEF1234, 4'b1100, 32'h0, 32'hFFFFBEEF);
        mem_op(1'b0, 2'b01, 1'b1, 32'h004, 32'h0, 0, 0, 32'h1234F00D, 4'b0011, 32'h0, 32'h0000F00D);
        mem_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD, 3, 0, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0000F00D);
        mem_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 0, 2, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0000F00D);
        mem_op(1'b1, 2'b10, 1'b0, 32'h010, 32'h01020304, 1, 0, 32'h0, 4'b1111, 32'h01020304, 32'h0000F00D);

        mis_op(2'b10, 32'h101, 32'h0000F00D);
        mis_op(2'b11, 32'h100, 32'h0000F00D);
        mis_op(2'b01, 32'h203, 32'h0000F00D);

        // Enable held high: one transaction per IDLE acceptance, back-to-back restart.
        lsu_en_i = 1'b1; lsu_op_i = 1'b0; lsu_op_size_i = 2'b10; lsu_unsigned_i = 1'b0;
        lsu_addr_i = 32'h400;
        tick();
        chk("hold_req1", {31'd0, data_req_o}, 32'd1);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("hold_wait_req", {31'd0, data_req_o}, 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
        tick();
        data_rvalid_i = 1'b0;
        chk("hold_valid1", {31'd0, lsu_valid_o}, 32'd1);
        chk("hold_rdata1", lsu_rdata_o, 32'h11111111);
        chk("hold_req_idle", {31'd0, data_req_o}, 32'd0);
        lsu_addr_i = 32'h408;
        tick();
        lsu_en_i = 1'b0;
        chk("hold_req2",  {31'd0, data_req_o}, 32'd1);
        chk("hold_addr2", data_addr_o, 32'h408);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h22222222;
        tick();
        data_rvalid_i = 1'b0;
        chk("hold_valid2", {31'd0, lsu_valid_o}, 32'd1);
        chk("hold_rdata2", lsu_rdata_o, 32'h22222222);
        tick();
        chk("hold_quiet_busy", {31'd0, lsu_busy_o}, 32'd0);
        chk("hold_quiet_req",  {31'd0, data_req_o}, 32'd0);

        // Asynchronous reset while waiting for the response.
        lsu_en_i = 1'b1; lsu_addr_i = 32'h500;
        tick();
        lsu_en_i = 1'b0;
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("pre_rst_busy", {31'd0, lsu_busy_o}, 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, lsu_busy_o},  32'd0);
        chk("arst_req",   {31'd0, data_req_o},  32'd0);
        chk("arst_valid", {31'd0, lsu_valid_o}, 32'd0);
        chk("arst_rdata", lsu_rdata_o,          32'd0);
        tick();
        #2;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h99999999;
        tick();
        data_rvalid_i = 1'b0;
        chk("late_valid", {31'd0, lsu_valid_o}, 32'd0);
        chk("late_busy",  {31'd0, lsu_busy_o},  32'd0);
        chk("late_rdata", lsu_rdata_o,          32'd0);
        mem_op(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 0, 0, 32'h12345678, 4'b1111, 32'h0, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/beta_exe_lsu.md
Name: beta_exe_lsu

Overview:
- Load & Store Unit of the execute stage.
- Accepts one memory operation per enable pulse from the execute control unit and issues it on a single-outstanding req/gnt/rvalid data-memory port.
- Aligns store data and generates byte enables; extracts and extends load data.
- Reports busy and completion to the execute-stage sequencing logic.

Parameters:
- DataWidth, 32, data bus width (only 32 supported)
- AddrWidth, 32, data address width

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- lsu_en_i  in  1  start request, sampled in IDLE only
- lsu_op_i  in  1  1 = store, 0 = load
- lsu_op_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_unsigned_i  in  1  load zero-extend when 1, sign-extend when 0
- lsu_addr_i  in  AddrWidth  effective byte address
- lsu_wdata_i  in  DataWidth  store data (LSB-justified)
- lsu_busy_o  out  1  operation in flight
- lsu_valid_o  out  1  one-cycle completion pulse
- lsu_misaligned_o  out  1  one-cycle error pulse
- lsu_rdata_o  out  DataWidth  extended load result, registered
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  AddrWidth  word-aligned address ({addr[31:2],2'b00})
- data_wdata_o  out  DataWidth  lane-replicated store data
- data_rvalid_i  in  1  response valid (read data or write ack)
- data_rdata_i  in  DataWidth  read data

Behaviour:
- Reset (async, any state): state IDLE, and all outputs 0. data_req_o drops immediately on reset assertion, with no completion pulse. Any captured operation is discarded.
- FSM states: IDLE, REQ, WAIT, ERR.
- lsu_busy_o = (state != IDLE), registered-state derived.
- IDLE:
  - On lsu_en_i=1: capture op, size, unsigned, addr[1:0], addr and wdata.
  - Misaligned if: size 01 with addr[0]=1; size 10 with addr[1:0]!=0; or size 11. Misaligned goes to ERR; otherwise go to REQ.
  - lsu_en_i=0: stay.
- REQ:
  - data_req_o=1. data_addr_o, data_we_o, data_be_o and data_wdata_o come from captured registers and stay stable until the grant.
  - data_gnt_i=1 -> WAIT, and data_req_o=0 next cycle.
  - data_rvalid_i in REQ is ignored.
- WAIT:
  - On data_rvalid_i=1, return to IDLE.
  - For loads, lsu_rdata_o is updated at that edge.
  - lsu_valid_o=1 during the first IDLE cycle.
- ERR:
  - Lasts one cycle, with no memory request.
  - Next state IDLE, with lsu_misaligned_o=1 and lsu_valid_o=0 in that IDLE cycle.
  - lsu_rdata_o is unchanged.
- Byte enables: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111, where off = addr[1:0].
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load data: take data_rdata_i >> (8*off), keep 8 or 16 or 32 bits, then sign- or zero-extend per lsu_unsigned_i.
- Stores leave lsu_rdata_o unchanged.
- Latency, zero-wait memory: lsu_en_i at cycle 0; req and busy at cycle 1; gnt at cycle 1; rvalid at cycle 2; busy=0 and lsu_valid_o=1 at cycle 3.
- Each gnt stall cycle or rvalid delay cycle adds one cycle.
- Busy is high for at least 1 cycle (ERR) or at least 2 cycles (memory op).
- lsu_en_i while busy is ignored, with no queueing.
- lsu_en_i in the same cycle as a lsu_valid_o/lsu_misaligned_o pulse (IDLE) is accepted as a new operation.
- Only one outstanding transaction at a time.

Test Plan:
- LW addr 0x100, zero-wait, rdata 0xDEADBEEF -> req at cycle 1, be=1111, addr 0x100; valid at cycle 3 with lsu_rdata_o=0xDEADBEEF; busy high in cycles 1-2.
- LB signed addr 0x203, rdata 0x80123456 -> be=1000, lsu_rdata_o=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD, gnt delayed 3 cycles -> req held 4 cycles with addr 0x300, we=1, be=1100, wdata 0xABCDABCD stable throughout; valid 1 cycle after rvalid.
- LW addr 0x101 or size 11 -> no data_req_o; busy high 1 cycle; lsu_misaligned_o pulse; lsu_rdata_o unchanged.
- lsu_en_i held high during an operation -> exactly one transaction per IDLE acceptance; a back-to-back enable in the valid-pulse cycle starts a second req on the next cycle.
- rstn_i asserted in WAIT -> busy, req and valid are 0 immediately. A late rvalid after reset release is ignored, and the next LW completes normally.
